// File: rtl/ysyx_mc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_mc_seq : multi-cycle fetch/execute/memory/writeback sequencer (npc).  |
// | Optional: YSYX_PERF_CNT_EN enables mcycle/minstret counters.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ysyx_mc_seq #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = 32'h8000_0000,
   parameter int               CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 ifu_req_valid,
   input  logic                 ifu_req_ready,
   output logic [WIDTH-1:0]     ifu_addr,
   input  logic                 ifu_rsp_valid,
   input  logic [31:0]          ifu_rsp_data,
   output logic [31:0]          inst,
   output logic [WIDTH-1:0]     pc,
   input  logic [WIDTH-1:0]     next_pc,
   input  logic                 dec_mem_re,
   input  logic                 dec_mem_we,
   input  logic                 dec_rd_we,
   input  logic                 dec_csr_we,
   output logic                 lsu_req_valid,
   input  logic                 lsu_req_ready,
   output logic                 lsu_req_we,
   input  logic                 lsu_rsp_valid,
   input  logic [WIDTH-1:0]     lsu_rsp_data,
   output logic [WIDTH-1:0]     rdata,
   output logic                 rf_we,
   output logic                 csr_we,
   output logic                 retire,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] mcycle,
   output logic [CNT_WIDTH-1:0] minstret
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_IWAIT = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_MWAIT = 3'd4,
      S_WB    = 3'd5
   } state_t;

   localparam logic [31:0] c_nop = 32'h0000_0013;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [31:0]      r_inst;
   logic [WIDTH-1:0] r_rdata;
   logic             r_is_load;

   // Load/store kind is captured at the MEM handshake so MWAIT never looks at decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_PC;
         r_inst    <= c_nop;
         r_rdata   <= '0;
         r_is_load <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IWAIT && ifu_rsp_valid)
            r_inst <= ifu_rsp_data;
         if (r_state == S_MEM && lsu_req_ready)
            r_is_load <= dec_mem_re & ~dec_mem_we;
         if (r_state == S_MWAIT && lsu_rsp_valid && r_is_load)
            r_rdata <= lsu_rsp_data;
         if (r_state == S_WB)
            r_pc <= next_pc;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_req_we    = 1'b0;
      rf_we         = 1'b0;
      csr_we        = 1'b0;
      retire        = 1'b0;
      case (r_state)
         S_FETCH: begin
            ifu_req_valid = 1'b1;
            if (ifu_req_ready) w_state_nxt = S_IWAIT;
         end
         S_IWAIT: begin
            if (ifu_rsp_valid) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_state_nxt = (dec_mem_re | dec_mem_we) ? S_MEM : S_WB;
         end
         S_MEM: begin
            lsu_req_valid = 1'b1;
            lsu_req_we    = dec_mem_we;
            if (lsu_req_ready) w_state_nxt = S_MWAIT;
         end
         S_MWAIT: begin
            if (lsu_rsp_valid) w_state_nxt = S_WB;
         end
         S_WB: begin
            rf_we       = dec_rd_we;
            csr_we      = dec_csr_we;
            retire      = 1'b1;
            w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   assign ifu_addr = r_pc;
   assign pc       = r_pc;
   assign inst     = r_inst;
   assign rdata    = r_rdata;
   assign state    = r_state;

`ifdef YSYX_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] c_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] r_mcycle;
   logic [CNT_WIDTH-1:0] r_minstret;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         r_mcycle <= r_mcycle + c_one;
         if (retire) r_minstret <= r_minstret + c_one;
      end
   end

   assign mcycle   = r_mcycle;
   assign minstret = r_minstret;
`else
   assign mcycle   = '0;
   assign minstret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_mc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ysyx_mc_seq : directed self-checking bench for ysyx_mc_seq.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ysyx_mc_seq;

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_IWAIT = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_MWAIT = 3'd4;
   localparam logic [2:0] S_WB    = 3'd5;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef YSYX_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_addr, ifu_rsp_data, inst, pc, next_pc;
   logic        dec_mem_re, dec_mem_we, dec_rd_we, dec_csr_we;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid;
   logic [31:0] lsu_rsp_data, rdata;
   logic        rf_we, csr_we, retire;
   logic [2:0]  state;
   logic [63:0] mcycle, minstret;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_rdata;

   always #5 clk = ~clk;

   // External next-PC logic: sequential flow.
   assign next_pc = pc + 32'd4;

   ysyx_mc_seq dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
      .inst(inst), .pc(pc), .next_pc(next_pc),
      .dec_mem_re(dec_mem_re), .dec_mem_we(dec_mem_we), .dec_rd_we(dec_rd_we), .dec_csr_we(dec_csr_we),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .rdata(rdata),
      .rf_we(rf_we), .csr_we(csr_we), .retire(retire), .state(state),
      .mcycle(mcycle), .minstret(minstret)
   );

   task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
      end
   endtask

   // Called at a negedge: everything visible must match the expected state.
   task automatic obs(input logic [2:0] es);
      chk("state", {61'd0, state}, {61'd0, es});
      chk("ifu_req_valid", {63'd0, ifu_req_valid}, {63'd0, es == S_FETCH});
      chk("ifu_addr", {32'd0, ifu_addr}, {32'd0, exp_pc});
      chk("pc", {32'd0, pc}, {32'd0, exp_pc});
      chk("lsu_req_valid", {63'd0, lsu_req_valid}, {63'd0, es == S_MEM});
      chk("lsu_req_we", {63'd0, lsu_req_we}, {63'd0, (es == S_MEM) && dec_mem_we});
      chk("retire", {63'd0, retire}, {63'd0, es == S_WB});
      chk("rf_we", {63'd0, rf_we}, {63'd0, (es == S_WB) && dec_rd_we});
      chk("csr_we", {63'd0, csr_we}, {63'd0, (es == S_WB) && dec_csr_we});
   endtask

   task automatic cyc(input logic ir, input logic iv, input logic lr, input logic lv);
      ifu_req_ready = ir;
      ifu_rsp_valid = iv;
      lsu_req_ready = lr;
      lsu_rsp_valid = lv;
      @(negedge clk);
   endtask

   // One instruction with fw/iw/mw/rw wait cycles on fetch-ready, fetch-rsp,
   // lsu-ready and lsu-rsp; stray valids are driven where they must be ignored.
   task automatic instr(input int fw, input int iw, input int mw, input int rw,
                        input logic re, input logic we, input logic rdwe, input logic csrwe,
                        input logic [31:0] idata, input logic [31:0] ldata);
      dec_mem_re   = re;
      dec_mem_we   = we;
      dec_rd_we    = rdwe;
      dec_csr_we   = csrwe;
      ifu_rsp_data = idata;
      lsu_rsp_data = ldata;
      for (int i = 0; i < fw; i++) begin obs(S_FETCH); cyc(1'b0, 1'b1, 1'b0, 1'b1); end
      obs(S_FETCH); cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < iw; i++) begin obs(S_IWAIT); cyc(1'b0, 1'b0, 1'b1, 1'b1); end
      obs(S_IWAIT); cyc(1'b0, 1'b1, 1'b0, 1'b0);
      obs(S_EXEC);
      chk("inst", {32'd0, inst}, {32'd0, idata});
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (re | we) begin
         for (int i = 0; i < mw; i++) begin obs(S_MEM); cyc(1'b0, 1'b1, 1'b0, 1'b1); end
         obs(S_MEM); cyc(1'b0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < rw; i++) begin obs(S_MWAIT); cyc(1'b1, 1'b1, 1'b0, 1'b0); end
         obs(S_MWAIT); cyc(1'b0, 1'b0, 1'b0, 1'b1);
         if (re && !we) exp_rdata = ldata;
      end
      obs(S_WB);
      chk("rdata", {32'd0, rdata}, {32'd0, exp_rdata});
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      exp_pc = exp_pc + 32'd4;
   endtask

   initial begin
      rst = 1'b1;
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = NOP;
      lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_data = '0;
      dec_mem_re = 1'b0; dec_mem_we = 1'b0; dec_rd_we = 1'b0; dec_csr_we = 1'b0;
      exp_pc = RST_PC;
      exp_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      obs(S_FETCH);
      chk("rst_inst", {32'd0, inst}, {32'd0, NOP});
      chk("rst_rdata", {32'd0, rdata}, 64'd0);
      chk("rst_mcycle", mcycle, 64'd0);
      chk("rst_minstret", minstret, 64'd0);

      // Ten zero-wait nops straight out of reset
      for (int n = 0; n < 10; n++)
         instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, NOP, 32'd0);
      chk("mcycle_10", mcycle, PERF ? 64'd40 : 64'd0);
      chk("minstret_10", minstret, PERF ? 64'd10 : 64'd0);
      chk("pc_after_10", {32'd0, pc}, {32'd0, RST_PC + 32'd40});

      // Fetch stalls: 3 cycles on ready, 2 on the response (retire at cycle 9)
      instr(3, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0010_0093, 32'd0);

      // CSR-writing instruction without rd write
      instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3052_9073, 32'd0);

      // Zero-wait load
      instr(0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2103, 32'hDEAD_BEEF);
      chk("rdata_load", {32'd0, rdata}, 64'hDEAD_BEEF);

      // Store with both strobes and memory wait states: rdata untouched
      instr(0, 0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0020_2023, 32'h1234_5678);
      chk("rdata_store", {32'd0, rdata}, 64'hDEAD_BEEF);

      // Load interrupted by reset in MWAIT
      dec_mem_re = 1'b1; dec_mem_we = 1'b0; dec_rd_we = 1'b1; dec_csr_we = 1'b0;
      ifu_rsp_data = 32'h0000_2183; lsu_rsp_data = 32'hCAFE_F00D;
      obs(S_FETCH); cyc(1'b1, 1'b0, 1'b0, 1'b0);
      obs(S_IWAIT); cyc(1'b0, 1'b1, 1'b0, 1'b0);
      obs(S_EXEC);  cyc(1'b0, 1'b0, 1'b0, 1'b0);
      obs(S_MEM);   cyc(1'b0, 1'b0, 1'b1, 1'b0);
      obs(S_MWAIT);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      exp_pc = RST_PC;
      exp_rdata = '0;
      obs(S_FETCH);
      chk("mwait_rst_mcycle", mcycle, 64'd0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      obs(S_FETCH);
      chk("late_rsp_rdata", {32'd0, rdata}, 64'd0);
      chk("late_rsp_inst", {32'd0, inst}, {32'd0, NOP});
      chk("late_rsp_minstret", minstret, 64'd0);

      // Recovery: one more load from the reset PC
      instr(0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2203, 32'h0BAD_CAFE);
      obs(S_FETCH);
      chk("minstret_after", minstret, PERF ? 64'd1 : 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_mc_seq.md
# ysyx_mc_seq

Multi-cycle instruction sequencer for the npc core. It replaces the divided-clock single-cycle scheme with a state machine on the full-rate clock. Instruction fetch and data memory are driven over valid/ready request and response handshakes. The block holds the PC and the latched instruction and load data, and issues one-cycle write pulses for the PC, register file and CSR file. Decode, ALU and next-PC logic stay combinational outside the block and are fed from `inst` and `pc`.

## Interface
Parameters:
- `WIDTH`, 32: address/data width.
- `RESET_PC`, 32'h8000_0000: PC value after reset.
- `CNT_WIDTH`, 64: performance counter width.

Ports:
- `clk`, in, 1: single clock, all logic on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `ifu_req_valid`, out, 1: fetch request.
- `ifu_req_ready`, in, 1: fetch request accepted.
- `ifu_addr`, out, WIDTH: fetch address, equal to `pc`.
- `ifu_rsp_valid`, in, 1: fetch data valid.
- `ifu_rsp_data`, in, 32: fetched instruction.
- `inst`, out, 32: latched instruction.
- `pc`, out, WIDTH: current PC.
- `next_pc`, in, WIDTH: next PC from the external PC logic.
- `dec_mem_re`, in, 1: decoded load.
- `dec_mem_we`, in, 1: decoded store.
- `dec_rd_we`, in, 1: decoded register write.
- `dec_csr_we`, in, 1: decoded CSR write.
- `lsu_req_valid`, out, 1: data request.
- `lsu_req_ready`, in, 1: data request accepted.
- `lsu_req_we`, out, 1: 1 = store.
- `lsu_rsp_valid`, in, 1: load data valid or store acknowledge.
- `lsu_rsp_data`, in, WIDTH: load data.
- `rdata`, out, WIDTH: latched load data.
- `rf_we`, out, 1: register-file write pulse.
- `csr_we`, out, 1: CSR write pulse.
- `retire`, out, 1: instruction retired.
- `state`, out, 3: current FSM state.
- `mcycle`, out, CNT_WIDTH: cycle counter.
- `minstret`, out, CNT_WIDTH: retired-instruction counter.

## Operation
State encodings: FETCH=0, IWAIT=1, EXEC=2, MEM=3, MWAIT=4, WB=5.

- **FETCH**
  - Assert `ifu_req_valid`.
  - On `ifu_req_valid & ifu_req_ready`, go to IWAIT.
  - `ifu_addr` is stable while valid is high.
- **IWAIT**
  - On `ifu_rsp_valid`, latch `ifu_rsp_data` into `inst` and go to EXEC.
- **EXEC**
  - Lasts one cycle; external decode and ALU settle from `inst`.
  - If `dec_mem_re | dec_mem_we`, go to MEM; otherwise go to WB.
- **MEM**
  - Assert `lsu_req_valid`, with `lsu_req_we = dec_mem_we`.
  - On handshake, go to MWAIT.
  - If `dec_mem_re` and `dec_mem_we` are both 1, the access is a store.
- **MWAIT**
  - On `lsu_rsp_valid`, go to WB.
  - For loads, also latch `lsu_rsp_data` into `rdata`.
  - For stores, the response is only an acknowledge; `rdata` is unchanged.
- **WB**
  - Lasts one cycle.
  - `rf_we = dec_rd_we`, `csr_we = dec_csr_we`, `retire = 1`.
  - `pc <= next_pc`.
  - Go to FETCH.
- The `dec_*` inputs and `next_pc` are sampled only in EXEC, MEM and WB. They are guaranteed stable there because `inst` and `pc` are held.
- `rf_we`, `csr_we` and `retire` are 0 in every state except WB.
- `ifu_rsp_valid` is ignored outside IWAIT. `lsu_rsp_valid` is ignored outside MWAIT.
- `next_pc` is taken as given; it is not realigned and no misalignment check is made.

## Timing
- **Reset values:**
  - `state` = FETCH, `pc` = RESET_PC.
  - `inst` = 32'h0000_0013 (nop); `rdata` = 0.
  - All pulse/valid outputs 0, except `ifu_req_valid`, which is 1 in the first cycle after reset.
  - Counters = 0.
- **Reset mid-transaction:** the outstanding request or response is abandoned. The memory side shares `rst`. No retire pulse is emitted.
- **Request handshake:** the request is accepted on the edge where valid and ready are both 1. Valid stays high until acceptance; ready may be high before valid.
- **Response handshake:** a response counts only from the cycle after acceptance.
- **Latency with zero-wait memory** (ready=1, response the cycle after acceptance):
  - Non-memory instruction: 4 cycles (FETCH, IWAIT, EXEC, WB).
  - Load or store: 6 cycles.
- **Wait states:** each wait cycle on ready or on the response adds exactly one cycle.
- **Visibility:** the new `pc` is visible in the cycle after WB, which is the FETCH cycle.

## Configuration
- `YSYX_PERF_CNT_EN` defined:
  - `mcycle` increments every cycle not in reset.
  - `minstret` increments on each `retire`.
  - Both wrap modulo 2^CNT_WIDTH.
- `YSYX_PERF_CNT_EN` undefined: both outputs are tied to 0 and no counter registers exist.

## Test plan
- **Zero-wait nop stream:**
  - Stimulus: `rst` for 2 cycles, then ready=1, responses the cycle after acceptance, data 32'h0000_0013, `next_pc` = `pc`+4.
  - Required: `retire` every 4 cycles; `pc` sequence 8000_0000, 8000_0004, 8000_0008.
- **Fetch stalls:**
  - Stimulus: `ifu_req_ready` low for 3 cycles, then `ifu_rsp_valid` delayed 2 cycles.
  - Required: `ifu_req_valid` and `ifu_addr` held throughout; first retire at cycle 9.
- **Load:**
  - Stimulus: `dec_mem_re`=1, `dec_rd_we`=1, `lsu_rsp_data`=32'hDEAD_BEEF.
  - Required: `lsu_req_we`=0; `rdata`=DEAD_BEEF in WB; `rf_we` pulses once; 6-cycle instruction.
- **Store with both decode strobes:**
  - Stimulus: `dec_mem_re`=`dec_mem_we`=1.
  - Required: `lsu_req_we`=1, `rdata` unchanged, `rf_we`=0.
- **Reset in MWAIT:**
  - Stimulus: assert `rst` while in MWAIT, then a late `lsu_rsp_valid`.
  - Required: `state`=0 and `pc`=8000_0000 the next cycle; the late response is ignored; no retire.
- **Counters (with `YSYX_PERF_CNT_EN`):**
  - Stimulus: run 10 nops zero-wait.
  - Required: `mcycle`=40 and `minstret`=10 after the 10th retire; both 0 when the macro is undefined.
